// File: rtl/num_check_pkg.sv
`default_nettype none
// ============================================================================
// Module  : num_check_pkg
// Purpose : Shared LFSR step function, FSM state encoding and counter widths
//           for the num_gen / num_check LFSR traffic pair.
// Revision: 1.0 - initial release
// ============================================================================
package num_check_pkg;

   localparam int LFSR_W   = 8;
   localparam int ERRCNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_REPORT = 2'd2,
      ST_FIN    = 2'd3
   } num_check_state_t;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

endpackage : num_check_pkg
`default_nettype wire

// File: rtl/num_check_if.sv
`default_nettype none
// ============================================================================
// Module  : num_check_if
// Purpose : Single-beat AXI-Stream link (valid/ready/data/last/dest).
// Revision: 1.0 - initial release
// ============================================================================
interface num_check_if #(
   parameter int TDATAW = 32,
   parameter int TDESTW = 4
);
   logic              TVALID;
   logic              TREADY;
   logic [TDATAW-1:0] TDATA;
   logic              TLAST;
   logic [TDESTW-1:0] TDEST;

   modport master (output TVALID, TDATA, TLAST, TDEST, input TREADY);
   modport slave  (input TVALID, TDATA, TLAST, TDEST, output TREADY);
endinterface : num_check_if
`default_nettype wire

// File: rtl/num_check_lfsr_seq.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_seq
// Purpose : LFSR register with synchronous seed load and single-step advance.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr_seq
   import num_check_pkg::*;
#(
   parameter int DW = LFSR_W
) (
   input  wire logic          CLK,
   input  wire logic          RST_N,
   input  wire logic          i_load,
   input  wire logic [DW-1:0] i_seed,
   input  wire logic          i_advance,
   output logic      [DW-1:0] o_q
);
   logic [DW-1:0] r_q;

   // Load wins over advance so a re-arm always restarts from the seed
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_seed;
      end else if (i_advance) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign o_q = r_q;
endmodule : lfsr_seq
`default_nettype wire

// File: rtl/num_check.sv
`default_nettype none
// ============================================================================
// Module  : num_check
// Purpose : AXIS receive endpoint that checks num_gen LFSR traffic, counts
//           mismatches and optionally reports status (NUM_CHECK_REPORT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module num_check
   import num_check_pkg::*;
#(
   parameter int                 TDATAW       = 32,
   parameter int                 TDESTW       = 4,
   parameter int                 TIDW         = 2,
   parameter int                 LFSR_DW      = 8,
   parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 8'h01,
   parameter int                 NUM_PACKETS  = 16,
   parameter logic [TDESTW-1:0]  REPORT_DEST  = 4'd3
) (
   input  wire logic                CLK,
   input  wire logic                RST_N,
   input  wire logic                START,
   output logic                     DONE,
   output logic                     PASS,
   output logic [ERRCNT_W-1:0]      ERR_CNT,
   output logic [TDATAW-1:0]        DATA_O,
   num_check_if.slave               AXIS_S,
   num_check_if.master              AXIS_M
);
   localparam int CNT_W = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

   num_check_state_t    r_state;
   num_check_state_t    w_state_nxt;
   logic [CNT_W-1:0]    r_rx_cnt;
   logic [ERRCNT_W-1:0] r_err_cnt;
   logic [ERRCNT_W-1:0] w_err_nxt;
   logic [TDATAW-1:0]   r_data;
   logic [LFSR_DW-1:0]  w_expected;
   logic [TDATAW-1:0]   w_expected_word;
   logic                w_s_ready;
   logic                w_start_run;
   logic                w_accept;
   logic                w_last_beat;
   logic                w_bad_beat;

   assign w_start_run     = START && ((r_state == ST_IDLE) || (r_state == ST_FIN));
   assign w_s_ready       = (r_state == ST_RECV);
   assign w_accept        = AXIS_S.TVALID && w_s_ready;
   assign w_last_beat     = (r_rx_cnt == CNT_W'(NUM_PACKETS - 1));
   assign w_expected_word = {{(TDATAW - LFSR_DW){1'b0}}, w_expected};
   assign w_bad_beat      = (AXIS_S.TDATA != w_expected_word) || !AXIS_S.TLAST;
   assign w_err_nxt       = (w_bad_beat && (r_err_cnt != '1)) ?
                            r_err_cnt + ERRCNT_W'(1) : r_err_cnt;

   lfsr_seq #(
      .DW        (LFSR_DW)
   ) u_lfsr (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .i_load    (w_start_run),
      .i_seed    (LFSR_DEFAULT),
      .i_advance (w_accept),
      .o_q       (w_expected)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_FIN: begin
            if (START) w_state_nxt = ST_RECV;
         end
         ST_RECV: begin
            if (w_accept && w_last_beat) begin
`ifdef NUM_CHECK_REPORT_EN
               w_state_nxt = ST_REPORT;
`else
               w_state_nxt = ST_FIN;
`endif
            end
         end
`ifdef NUM_CHECK_REPORT_EN
         ST_REPORT: begin
            if (AXIS_M.TREADY) w_state_nxt = ST_FIN;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         r_rx_cnt  <= '0;
         r_err_cnt <= '0;
         r_data    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_run) begin
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
         end else if (w_accept) begin
            r_rx_cnt  <= r_rx_cnt + CNT_W'(1);
            r_err_cnt <= w_err_nxt;
            r_data    <= AXIS_S.TDATA;
         end
      end
   end

   assign AXIS_S.TREADY = w_s_ready;
   assign DONE          = (r_state == ST_FIN);
   assign PASS          = DONE && (r_err_cnt == '0);
   assign ERR_CNT       = r_err_cnt;
   assign DATA_O        = r_data;

   logic [TIDW-1:0] w_unused_tid;
   logic            w_unused;
   assign w_unused_tid = '0;

`ifdef NUM_CHECK_REPORT_EN
   logic [TDATAW-1:0] r_m_tdata;
   logic              r_m_tlast;
   logic [TDESTW-1:0] r_m_tdest;
   logic [TDATAW-1:0] w_status;

   // Status uses the post-update count so the final beat's verdict is included
   always_comb begin
      w_status                 = '0;
      w_status[ERRCNT_W-1:0]   = w_err_nxt;
      w_status[31]             = (w_err_nxt == '0);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_m_tdata <= '0;
         r_m_tlast <= 1'b0;
         r_m_tdest <= '0;
      end else if (w_accept && w_last_beat) begin
         r_m_tdata <= w_status;
         r_m_tlast <= 1'b1;
         r_m_tdest <= REPORT_DEST;
      end
   end

   assign AXIS_M.TVALID = (r_state == ST_REPORT);
   assign AXIS_M.TDATA  = r_m_tdata;
   assign AXIS_M.TLAST  = r_m_tlast;
   assign AXIS_M.TDEST  = r_m_tdest;
   assign w_unused      = ^{AXIS_S.TDEST, w_unused_tid};
`else
   assign AXIS_M.TVALID = 1'b0;
   assign AXIS_M.TDATA  = '0;
   assign AXIS_M.TLAST  = 1'b0;
   assign AXIS_M.TDEST  = '0;
   assign w_unused      = ^{AXIS_S.TDEST, AXIS_M.TREADY, w_unused_tid};
`endif

endmodule : num_check
`default_nettype wire

// File: tb/tb_num_check.sv
`default_nettype none
// ============================================================================
// Module  : tb_num_check
// Purpose : Directed self-checking bench for num_check (LFSR seed 8'h01).
// Revision: 1.0 - initial release
// ============================================================================
module tb_num_check;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic        DONE, PASS;
   logic [15:0] ERR_CNT;
   logic [31:0] DATA_O;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Seed 8'h01 advanced k times under x^8+x^6+x^5+x^4+1
   logic [7:0] exp_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                                8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};

   num_check_if #(.TDATAW(32), .TDESTW(4)) s_if ();
   num_check_if #(.TDATAW(32), .TDESTW(4)) m_if ();

   num_check u_dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .START   (START),
      .DONE    (DONE),
      .PASS    (PASS),
      .ERR_CNT (ERR_CNT),
      .DATA_O  (DATA_O),
      .AXIS_S  (s_if),
      .AXIS_M  (m_if)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l);
      int n = 0;
      s_if.TVALID = 1'b1;
      s_if.TDATA  = d;
      s_if.TLAST  = l;
      while (s_if.TREADY !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_timeout: TREADY=%b after %0d cycles, want 1", s_if.TREADY, n);
      end
      tick();
      s_if.TVALID = 1'b0;
   endtask

   task automatic send_frame(input int first, input int bad_idx, input int nolast_idx);
      for (int k = first; k < 16; k++) begin
         send_beat({24'h0, exp_seq[k]} ^ ((k == bad_idx) ? 32'h1 : 32'h0), (k != nolast_idx));
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (DONE !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (lat >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: DONE=%b after %0d cycles, want 1", DONE, lat);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({DONE, PASS, s_if.TREADY} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: DONE/PASS/TREADY=%b want 000", {DONE, PASS, s_if.TREADY});
      end
      n_tests++;
      if (ERR_CNT !== 16'h0 || DATA_O !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_regs: ERR_CNT=%h DATA_O=%h want 0/0", ERR_CNT, DATA_O);
      end
      n_tests++;
      if ({m_if.TVALID, m_if.TDATA, m_if.TLAST, m_if.TDEST} !== 38'h0) begin
         n_fail++;
         $display("FAIL reset_master: TVALID=%b TDATA=%h TLAST=%b TDEST=%h want 0",
                  m_if.TVALID, m_if.TDATA, m_if.TLAST, m_if.TDEST);
      end
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_clean();
      int lat;
      pulse_start();
      n_tests++;
      if (s_if.TREADY !== 1'b1 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_armed: TREADY=%b DONE=%b want 1/0", s_if.TREADY, DONE);
      end
      send_beat(32'h01, 1'b1);
      send_beat(32'h02, 1'b1);
      n_tests++;
      if (DATA_O !== 32'h02) begin
         n_fail++;
         $display("FAIL clean_second_word: DATA_O=%h want 00000002", DATA_O);
      end
      send_frame(2, -1, -1);
      wait_done(lat);
      n_tests++;
`ifdef NUM_CHECK_REPORT_EN
      if (lat !== 1) begin
`else
      if (lat !== 0) begin
`endif
         n_fail++;
         $display("FAIL clean_done_latency: %0d cycles after last accept", lat);
      end
      n_tests++;
      if (PASS !== 1'b1 || ERR_CNT !== 16'h0) begin
         n_fail++;
         $display("FAIL clean_result: PASS=%b ERR_CNT=%h want 1/0000", PASS, ERR_CNT);
      end
      n_tests++;
      if (DATA_O !== 32'h25) begin
         n_fail++;
         $display("FAIL clean_last_word: DATA_O=%h want 00000025", DATA_O);
      end
`ifndef NUM_CHECK_REPORT_EN
      m_if.TREADY = 1'b0;
      tick();
      n_tests++;
      if ({m_if.TVALID, m_if.TDATA, m_if.TLAST, m_if.TDEST} !== 38'h0) begin
         n_fail++;
         $display("FAIL master_tied: TVALID=%b TDATA=%h want 0/0", m_if.TVALID, m_if.TDATA);
      end
      m_if.TREADY = 1'b1;
`endif
   endtask

   task automatic test_corrupt();
      int lat;
      pulse_start();
      n_tests++;
      if (ERR_CNT !== 16'h0 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL corrupt_rearm: ERR_CNT=%h DONE=%b want 0000/0", ERR_CNT, DONE);
      end
      send_frame(0, 5, 9);
`ifdef NUM_CHECK_REPORT_EN
      n_tests++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL corrupt_status: TVALID=%b TDATA=%h want 1/00000002", m_if.TVALID, m_if.TDATA);
      end
`endif
      wait_done(lat);
      n_tests++;
      if (ERR_CNT !== 16'h2 || PASS !== 1'b0) begin
         n_fail++;
         $display("FAIL corrupt_result: ERR_CNT=%h PASS=%b want 0002/0", ERR_CNT, PASS);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      s_if.TVALID = 1'b1;
      s_if.TDATA  = 32'h01;
      s_if.TLAST  = 1'b1;
      repeat (5) tick();
      n_tests++;
      if (s_if.TREADY !== 1'b0 || ERR_CNT !== 16'h2 || DATA_O !== 32'h25) begin
         n_fail++;
         $display("FAIL bp_held: TREADY=%b ERR_CNT=%h DATA_O=%h want 0/0002/00000025",
                  s_if.TREADY, ERR_CNT, DATA_O);
      end
      pulse_start();
      n_tests++;
      if (ERR_CNT !== 16'h0 || DATA_O !== 32'h25 || s_if.TREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_start: ERR_CNT=%h DATA_O=%h TREADY=%b want 0000/00000025/1",
                  ERR_CNT, DATA_O, s_if.TREADY);
      end
      send_frame(0, -1, -1);
      wait_done(lat);
      n_tests++;
      if (PASS !== 1'b1 || ERR_CNT !== 16'h0 || DATA_O !== 32'h25) begin
         n_fail++;
         $display("FAIL bp_result: PASS=%b ERR_CNT=%h DATA_O=%h want 1/0000/00000025",
                  PASS, ERR_CNT, DATA_O);
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      pulse_start();
      for (int k = 0; k < 7; k++) begin
         send_beat({24'h0, exp_seq[k]} ^ ((k == 3) ? 32'h100 : 32'h0), 1'b1);
      end
      n_tests++;
      if (ERR_CNT !== 16'h1 || DATA_O !== 32'h47) begin
         n_fail++;
         $display("FAIL midrun_state: ERR_CNT=%h DATA_O=%h want 0001/00000047", ERR_CNT, DATA_O);
      end
      RST_N = 1'b0;
      #2;
      n_tests++;
      if ({DONE, PASS, s_if.TREADY, m_if.TVALID} !== 4'b0000 || ERR_CNT !== 16'h0 || DATA_O !== 32'h0) begin
         n_fail++;
         $display("FAIL midrun_reset: DONE=%b TREADY=%b ERR_CNT=%h DATA_O=%h want 0/0/0000/0",
                  DONE, s_if.TREADY, ERR_CNT, DATA_O);
      end
      tick();
      RST_N = 1'b1;
      tick();
      pulse_start();
      send_frame(0, -1, -1);
      wait_done(lat);
      n_tests++;
      if (PASS !== 1'b1 || ERR_CNT !== 16'h0) begin
         n_fail++;
         $display("FAIL midrun_rerun: PASS=%b ERR_CNT=%h want 1/0000", PASS, ERR_CNT);
      end
   endtask

`ifdef NUM_CHECK_REPORT_EN
   task automatic test_report();
      m_if.TREADY = 1'b0;
      pulse_start();
      send_frame(0, -1, -1);
      for (int c = 0; c < 10; c++) begin
         n_tests++;
         if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'h8000_0000 || m_if.TLAST !== 1'b1 ||
             m_if.TDEST !== 4'd3 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL report_hold[%0d]: TVALID=%b TDATA=%h TLAST=%b TDEST=%h DONE=%b want 1/80000000/1/3/0",
                     c, m_if.TVALID, m_if.TDATA, m_if.TLAST, m_if.TDEST, DONE);
         end
         tick();
      end
      m_if.TREADY = 1'b1;
      tick();
      n_tests++;
      if (m_if.TVALID !== 1'b0 || DONE !== 1'b1 || PASS !== 1'b1) begin
         n_fail++;
         $display("FAIL report_release: TVALID=%b DONE=%b PASS=%b want 0/1/1", m_if.TVALID, DONE, PASS);
      end
   endtask
`endif

   initial begin
      s_if.TVALID = 1'b0;
      s_if.TDATA  = '0;
      s_if.TLAST  = 1'b0;
      s_if.TDEST  = 4'd7;
      m_if.TREADY = 1'b1;
      test_reset();
      test_clean();
      test_corrupt();
      test_backpressure();
      test_reset_midrun();
`ifdef NUM_CHECK_REPORT_EN
      test_report();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule : tb_num_check
`default_nettype wire
